// File: rtl/fb_write_arbiter_pkg.sv
// Shared types and counter widths for the framebuffer write-port arbiter.
package fb_write_arbiter_pkg;

    typedef enum logic {
        WAIT_VS = 1'b0,
        RUN     = 1'b1
    } arb_state_e;

    localparam int PIX_CNT_BITS   = 21;
    localparam int FRAME_CNT_BITS = 16;
    localparam int ERR_CNT_BITS   = 8;

endpackage

// File: rtl/fb_frame_auditor.sv
// Per-frame pixel audit: counts forwarded pixels and compares each finished
// frame against the committed width x height.
module fb_frame_auditor
    import fb_write_arbiter_pkg::*;
#(
    parameter int W_BITS = 11,
    parameter int H_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic                      pix_we,
    input  logic                      frame_end,
    input  logic [W_BITS-1:0]         width,
    input  logic [H_BITS-1:0]         height,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt,
    output logic [ERR_CNT_BITS-1:0]   err_cnt
);

    logic [PIX_CNT_BITS-1:0]   pix_q, pix_d;
    logic [PIX_CNT_BITS-1:0]   target;
    logic                      first_q, first_d;
    logic [FRAME_CNT_BITS-1:0] frame_q, frame_d;
    logic [ERR_CNT_BITS-1:0]   err_q, err_d;

    always_comb begin
        target  = PIX_CNT_BITS'(width) * PIX_CNT_BITS'(height);
        pix_d   = pix_q;
        first_d = first_q;
        frame_d = frame_q;
        err_d   = err_q;
        if (clear) begin
            pix_d   = '0;
            first_d = 1'b1;
        end else if (frame_end) begin
            // A vsync before any pixel since the commit is a held frame-start
            // pulse, not the end of a real frame.
            if (!first_q) begin
                frame_d = frame_q + FRAME_CNT_BITS'(1);
                if ((pix_q != target) && (err_q != '1)) begin
                    err_d = err_q + ERR_CNT_BITS'(1);
                end
            end
            pix_d   = PIX_CNT_BITS'(pix_we);
            first_d = 1'b0;
        end else if (pix_we) begin
            first_d = 1'b0;
            if (pix_q != '1) begin
                pix_d = pix_q + PIX_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q   <= '0;
            first_q <= 1'b1;
            frame_q <= '0;
            err_q   <= '0;
        end else begin
            pix_q   <= pix_d;
            first_q <= first_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign frame_cnt = frame_q;
    assign err_cnt   = err_q;

endmodule

// File: rtl/fb_write_arbiter.sv
// Selects one of two pixel sources for the framebuffer write port; switches
// only at a vsync of the newly selected source so frames are never torn.
module fb_write_arbiter
    import fb_write_arbiter_pkg::*;
#(
    parameter int COLOR_BITS = 18,
    parameter int W_BITS     = 11,
    parameter int H_BITS     = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      fb_ready,
    input  logic                      sel,
    input  logic                      s0_vsync,
    input  logic                      s1_vsync,
    input  logic                      s0_we,
    input  logic                      s1_we,
    input  logic [COLOR_BITS-1:0]     s0_data,
    input  logic [COLOR_BITS-1:0]     s1_data,
    input  logic [W_BITS-1:0]         s0_width,
    input  logic [W_BITS-1:0]         s1_width,
    input  logic [H_BITS-1:0]         s0_height,
    input  logic [H_BITS-1:0]         s1_height,
    input  logic [W_BITS-1:0]         s0_disp_width,
    input  logic [W_BITS-1:0]         s1_disp_width,
    output logic                      fb_vsync,
    output logic                      fb_we,
    output logic [COLOR_BITS-1:0]     fb_data,
    output logic [W_BITS-1:0]         fb_width,
    output logic [H_BITS-1:0]         fb_height,
    output logic [W_BITS-1:0]         fb_disp_width,
    output logic                      active,
    output logic                      locked,
    output logic [FRAME_CNT_BITS-1:0] frame_cnt,
    output logic [ERR_CNT_BITS-1:0]   err_cnt
);

    arb_state_e              state_q, state_d;
    logic                    active_q, active_d;
    logic                    fb_vsync_q, fb_vsync_d;
    logic                    fb_we_q, fb_we_d;
    logic [COLOR_BITS-1:0]   fb_data_q, fb_data_d;
    logic [W_BITS-1:0]       fb_width_q, fb_width_d;
    logic [H_BITS-1:0]       fb_height_q, fb_height_d;
    logic [W_BITS-1:0]       fb_disp_width_q, fb_disp_width_d;

    logic                    src_vsync, src_we;
    logic [COLOR_BITS-1:0]   src_data;
    logic [W_BITS-1:0]       src_width, src_disp_width;
    logic [H_BITS-1:0]       src_height;
    logic                    commit, forward;

    // Whenever anything is forwarded or committed, the source is the one
    // selected by sel, so a single mux serves both paths.
    always_comb begin
        src_vsync      = sel ? s1_vsync      : s0_vsync;
        src_we         = sel ? s1_we         : s0_we;
        src_data       = sel ? s1_data       : s0_data;
        src_width      = sel ? s1_width      : s0_width;
        src_height     = sel ? s1_height     : s0_height;
        src_disp_width = sel ? s1_disp_width : s0_disp_width;
        commit  = fb_ready && src_vsync && ((state_q == WAIT_VS) || (sel != active_q));
        forward = fb_ready && (state_q == RUN) && (sel == active_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_VS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!fb_ready) begin
            state_d = WAIT_VS;
        end else if (commit) begin
            state_d = RUN;
        end else if ((state_q == RUN) && (sel != active_q)) begin
            state_d = WAIT_VS;
        end
    end

    always_comb begin
        active_d        = active_q;
        fb_vsync_d      = 1'b0;
        fb_we_d         = 1'b0;
        fb_data_d       = '0;
        fb_width_d      = fb_width_q;
        fb_height_d     = fb_height_q;
        fb_disp_width_d = fb_disp_width_q;
        if (commit) begin
            active_d        = sel;
            fb_vsync_d      = 1'b1;
            fb_width_d      = src_width;
            fb_height_d     = src_height;
            fb_disp_width_d = src_disp_width;
        end else if (forward) begin
            fb_vsync_d = src_vsync;
            fb_we_d    = src_we;
            fb_data_d  = src_data;
            if (src_vsync) begin
                fb_width_d      = src_width;
                fb_height_d     = src_height;
                fb_disp_width_d = src_disp_width;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q        <= 1'b0;
            fb_vsync_q      <= 1'b0;
            fb_we_q         <= 1'b0;
            fb_data_q       <= '0;
            fb_width_q      <= '0;
            fb_height_q     <= '0;
            fb_disp_width_q <= '0;
        end else begin
            active_q        <= active_d;
            fb_vsync_q      <= fb_vsync_d;
            fb_we_q         <= fb_we_d;
            fb_data_q       <= fb_data_d;
            fb_width_q      <= fb_width_d;
            fb_height_q     <= fb_height_d;
            fb_disp_width_q <= fb_disp_width_d;
        end
    end

    // Geometry used for the audit is the committed one, not the live inputs.
    fb_frame_auditor #(
        .W_BITS (W_BITS),
        .H_BITS (H_BITS)
    ) u_auditor (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (commit),
        .pix_we    (forward && src_we),
        .frame_end (forward && src_vsync),
        .width     (fb_width_q),
        .height    (fb_height_q),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    assign fb_vsync      = fb_vsync_q;
    assign fb_we         = fb_we_q;
    assign fb_data       = fb_data_q;
    assign fb_width      = fb_width_q;
    assign fb_height     = fb_height_q;
    assign fb_disp_width = fb_disp_width_q;
    assign active        = active_q;
    assign locked        = (state_q == RUN);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed plus randomized bench for fb_write_arbiter against a rule-level
// model of frame selection and pixel auditing.
module tb_fb_write_arbiter;
  localparam int CB = 18;
  localparam int WB = 11;
  localparam int HB = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic fb_ready = 1'b0, sel = 1'b0;
  logic s0_vsync = 1'b0, s1_vsync = 1'b0, s0_we = 1'b0, s1_we = 1'b0;
  logic [CB-1:0] s0_data = '0, s1_data = '0;
  logic [WB-1:0] s0_width = '0, s1_width = '0, s0_disp_width = '0, s1_disp_width = '0;
  logic [HB-1:0] s0_height = '0, s1_height = '0;
  logic fb_vsync, fb_we, active, locked;
  logic [CB-1:0] fb_data;
  logic [WB-1:0] fb_width, fb_disp_width;
  logic [HB-1:0] fb_height;
  logic [15:0] frame_cnt;
  logic [7:0] err_cnt;

  fb_write_arbiter #(.COLOR_BITS(CB), .W_BITS(WB), .H_BITS(HB)) dut (
    .clk(clk), .rst_n(rst_n), .fb_ready(fb_ready), .sel(sel),
    .s0_vsync(s0_vsync), .s1_vsync(s1_vsync), .s0_we(s0_we), .s1_we(s1_we),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_width(s0_width), .s1_width(s1_width),
    .s0_height(s0_height), .s1_height(s1_height),
    .s0_disp_width(s0_disp_width), .s1_disp_width(s1_disp_width),
    .fb_vsync(fb_vsync), .fb_we(fb_we), .fb_data(fb_data),
    .fb_width(fb_width), .fb_height(fb_height), .fb_disp_width(fb_disp_width),
    .active(active), .locked(locked), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit m_run, m_active, m_first;
  int m_w, m_h, m_dw, m_pix, m_frames, m_errs;
  bit e_vsync, e_we;
  logic [CB-1:0] exp_q[$];

  task automatic model_reset();
    m_run = 0; m_active = 0; m_first = 1;
    m_w = 0; m_h = 0; m_dw = 0; m_pix = 0; m_frames = 0; m_errs = 0;
    e_vsync = 0; e_we = 0;
    exp_q.delete();
  endtask

  // One clock of the selection/audit rules, evaluated on the inputs about to be sampled.
  task automatic model_step();
    bit sv, swe;
    logic [CB-1:0] sd;
    int sw, sh, sdw;
    sv  = sel ? s1_vsync : s0_vsync;
    swe = sel ? s1_we : s0_we;
    sd  = sel ? s1_data : s0_data;
    sw  = sel ? int'(s1_width) : int'(s0_width);
    sh  = sel ? int'(s1_height) : int'(s0_height);
    sdw = sel ? int'(s1_disp_width) : int'(s0_disp_width);
    e_vsync = 0;
    e_we = 0;
    if (!fb_ready) begin
      m_run = 0;
    end else if (sv && (!m_run || sel != m_active)) begin
      m_run = 1; m_active = sel;
      m_w = sw; m_h = sh; m_dw = sdw;
      m_pix = 0; m_first = 1;
      e_vsync = 1;
    end else if (m_run && sel == m_active) begin
      e_vsync = sv;
      e_we = swe;
      if (swe) exp_q.push_back(sd);
      if (sv) begin
        if (!m_first) begin
          m_frames = (m_frames + 1) % 65536;
          if (m_pix != m_w * m_h) m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end
        m_pix = swe ? 1 : 0;
        m_first = 0;
        m_w = sw; m_h = sh; m_dw = sdw;
      end else if (swe) begin
        m_pix = m_pix + 1;
        m_first = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [CB-1:0] d;
    model_step();
    @(posedge clk);
    #1;
    chk("fb_vsync", 32'(fb_vsync), 32'(e_vsync));
    chk("fb_we", 32'(fb_we), 32'(e_we));
    if (e_we) begin
      d = exp_q.pop_front();
      if (fb_we) chk("fb_data", 32'(fb_data), 32'(d));
    end
    chk("fb_width", 32'(fb_width), 32'(m_w));
    chk("fb_height", 32'(fb_height), 32'(m_h));
    chk("fb_disp_width", 32'(fb_disp_width), 32'(m_dw));
    chk("active", 32'(active), 32'(m_active));
    chk("locked", 32'(locked), 32'(m_run));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    chk("err_cnt", 32'(err_cnt), 32'(m_errs));
  endtask

  task automatic drive(input bit src, input bit vs, input bit we);
    logic [CB-1:0] d_main, d_noise;
    d_main  = CB'($urandom_range(0, (1 << CB) - 1));
    d_noise = CB'($urandom_range(0, (1 << CB) - 1));
    if (src) begin
      s1_vsync = vs; s1_we = we; s1_data = d_main;
      s0_vsync = ($urandom_range(0, 15) == 0); s0_we = 1'($urandom_range(0, 1)); s0_data = d_noise;
    end else begin
      s0_vsync = vs; s0_we = we; s0_data = d_main;
      s1_vsync = ($urandom_range(0, 15) == 0); s1_we = 1'($urandom_range(0, 1)); s1_data = d_noise;
    end
    tick();
  endtask

  task automatic pixels(input bit src, input int n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) drive(src, 1'b0, 1'b0);
      drive(src, 1'b0, 1'b1);
    end
  endtask

  task automatic vsync_cycle(input bit src);
    drive(src, 1'b1, 1'b0);
  endtask

  task automatic frame_on(input bit src, input int npix, input bit vs_we);
    bit w;
    w = (npix > 0) ? vs_we : 1'b0;
    drive(src, 1'b1, w);
    pixels(src, npix - int'(w));
  endtask

  task automatic set_geom(input bit src, input int w, input int h, input int dw);
    if (src) begin
      s1_width = WB'(w); s1_height = HB'(h); s1_disp_width = WB'(dw);
    end else begin
      s0_width = WB'(w); s0_height = HB'(h); s0_disp_width = WB'(dw);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vsync"}, 32'(fb_vsync), 0);
    chk({tag, "_we"}, 32'(fb_we), 0);
    chk({tag, "_data"}, 32'(fb_data), 0);
    chk({tag, "_width"}, 32'(fb_width), 0);
    chk({tag, "_height"}, 32'(fb_height), 0);
    chk({tag, "_disp"}, 32'(fb_disp_width), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_frames"}, 32'(frame_cnt), 0);
    chk({tag, "_errs"}, 32'(err_cnt), 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w, h, npix;
    bit vs_we;
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full frame on source 0, closed by its next vsync.
    set_geom(0, 16, 12, 40);
    set_geom(1, 8, 7, 1080);
    fb_ready = 1'b1;
    sel = 1'b0;
    frame_on(0, 192, 1'b0);
    vsync_cycle(0);
    chk("s1_frame_cnt", 32'(frame_cnt), 1);
    chk("s1_err_cnt", 32'(err_cnt), 0);
    chk("s1_fb_width", 32'(fb_width), 16);

    // One pixel short.
    pixels(0, 191);
    vsync_cycle(0);
    chk("short_err_cnt", 32'(err_cnt), 1);
    chk("short_frame_cnt", 32'(frame_cnt), 2);

    // Mid-frame switch to source 1, which starts its frame later.
    pixels(0, 50);
    sel = 1'b1;
    repeat (60) drive(1, 1'b0, 1'b0);
    chk("gap_we", 32'(fb_we), 0);
    chk("gap_locked", 32'(locked), 0);
    vsync_cycle(1);
    chk("sw_vsync", 32'(fb_vsync), 1);
    chk("sw_width", 32'(fb_width), 8);
    chk("sw_height", 32'(fb_height), 7);
    chk("sw_disp", 32'(fb_disp_width), 1080);
    chk("sw_active", 32'(active), 1);
    chk("sw_err_cnt", 32'(err_cnt), 1);
    pixels(1, 30);

    // Switch back in the exact cycle the new source's vsync arrives.
    sel = 1'b0;
    vsync_cycle(0);
    chk("same_cyc_locked", 32'(locked), 1);
    chk("same_cyc_active", 32'(active), 0);
    chk("same_cyc_vsync", 32'(fb_vsync), 1);
    pixels(0, 192);
    vsync_cycle(0);
    chk("same_cyc_frames", 32'(frame_cnt), 3);

    // fb_ready drop mid-frame.
    pixels(0, 60);
    fb_ready = 1'b0;
    repeat (10) drive(0, 1'b0, 1'b1);
    chk("nrdy_we", 32'(fb_we), 0);
    chk("nrdy_locked", 32'(locked), 0);
    fb_ready = 1'b1;
    pixels(0, 5);
    chk("nrdy_wait", 32'(locked), 0);
    vsync_cycle(0);
    chk("nrdy_relock", 32'(locked), 1);
    pixels(0, 192);
    vsync_cycle(0);
    chk("nrdy_frames", 32'(frame_cnt), 4);
    chk("nrdy_errs", 32'(err_cnt), 1);

    // Geometry change on the live source mid-frame stays hidden until vsync.
    pixels(0, 100);
    set_geom(0, 20, 5, 60);
    pixels(0, 1);
    chk("geo_hold", 32'(fb_width), 16);
    pixels(0, 91);
    vsync_cycle(0);
    chk("geo_frames", 32'(frame_cnt), 5);
    chk("geo_errs", 32'(err_cnt), 1);
    chk("geo_new", 32'(fb_width), 20);

    // Random frames, switches, ready glitches and vsync+we coincidence.
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 4) == 0) begin
        sel = ~sel;
        repeat ($urandom_range(0, 20)) drive(sel, 1'b0, 1'b0);
      end
      if ($urandom_range(0, 2) == 0) begin
        w = $urandom_range(1, 20);
        h = $urandom_range(1, 12);
        set_geom(sel, w, h, $urandom_range(1, 2047));
      end
      npix = sel ? int'(s1_width) * int'(s1_height) : int'(s0_width) * int'(s0_height);
      if ($urandom_range(0, 3) == 0) npix = npix + (($urandom_range(0, 1) == 0) ? -1 : 1);
      vs_we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        fb_ready = 1'b0;
        repeat ($urandom_range(1, 5)) drive(sel, 1'b0, 1'b1);
        fb_ready = 1'b1;
      end
      frame_on(sel, npix, vs_we);
    end
    vsync_cycle(sel);

    // Error counter saturation with tiny short frames.
    sel = 1'b0;
    set_geom(0, 2, 2, 4);
    vsync_cycle(0);
    repeat (260) begin
      drive(0, 1'b0, 1'b1);
      drive(0, 1'b1, 1'b0);
    end
    chk("err_saturate", 32'(err_cnt), 255);

    // Asynchronous reset in the middle of a frame.
    pixels(0, 1);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_rst");
    model_reset();
    #2 rst_n = 1'b1;
    drive(0, 1'b0, 1'b1);
    drive(0, 1'b0, 1'b1);
    chk("post_rst_wait", 32'(locked), 0);
    vsync_cycle(0);
    chk("post_rst_lock", 32'(locked), 1);
    chk("post_rst_width", 32'(fb_width), 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
